background_animator: RTL and testbench

- Parametrised successor to the static OLED background path: takes the per-pixel background colour (RGB565, 96x64 OLED, 13-bit pixel index) and applies a tick-driven animation before it reaches the OLED mux.
- Modes: passthrough, brightness pulse (fade), channel rotation, invert. A hit-flash override can be triggered at any time.
- Sits between the background ROM lookup and the sprite/overlay compositor.
- Output is registered, with the pixel index realigned alongside it.

---
 rtl/background_animator.sv | 155 +++++++++++++++
 tb/tb_background_animator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/background_animator.sv
// Tick-driven animation stage between the background ROM lookup and the compositor.
// Applies fade, channel rotation or invert to RGB565 pixels, with a white hit-flash override.
module background_animator #(
  parameter int unsigned TICK_DIV    = 10_000_000,
  parameter int unsigned PIX_W       = 13,
  parameter int unsigned LEVEL_BITS  = 4,
  parameter int unsigned FLASH_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  flash_req,
  input  logic [PIX_W-1:0]      pixel_index,
  input  logic [15:0]           bg_colour,
  output logic [PIX_W-1:0]      pixel_index_q,
  output logic [15:0]           oled_colour,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  flash_active
);

  localparam int unsigned CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FL_W   = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS + 1) : 1;
  localparam int unsigned K_W    = LEVEL_BITS + 1;
  localparam int unsigned PR_W   = 5 + K_W;
  localparam int unsigned PG_W   = 6 + K_W;
  localparam logic [LEVEL_BITS-1:0] MAX_LEVEL = '1;
  localparam logic [CNT_W-1:0]      TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [FL_W-1:0]       FLASH_LOAD = FL_W'(FLASH_TICKS);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick_c;
  logic [1:0]       mode_q;
  logic             mode_change_c;
  dir_t             dir;
  logic [1:0]       phase;
  logic [FL_W-1:0]  flash_cnt;
  logic [FL_W-1:0]  flash_cnt_d_c;
  logic [15:0]      colour_c;

  assign tick_c        = enable && (tick_cnt == TICK_LAST);
  assign mode_change_c = (mode != mode_q);

  // Animation step divider; holds while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (enable) begin
      tick_cnt <= tick_c ? '0 : tick_cnt + CNT_W'(1);
    end
  end

  // Triangle fade and rotation phase; a mode change restarts both and beats a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 2'd0;
      level  <= '0;
      dir    <= DIR_UP;
      phase  <= 2'd0;
    end else begin
      mode_q <= mode;
      if (mode_change_c) begin
        level <= '0;
        dir   <= DIR_UP;
        phase <= 2'd0;
      end else if (tick_c) begin
        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        case (dir)
          DIR_UP: begin
            if (level == MAX_LEVEL) begin
              dir   <= DIR_DOWN;
              level <= MAX_LEVEL - LEVEL_BITS'(1);
            end else begin
              level <= level + LEVEL_BITS'(1);
            end
          end
          default: begin
            if (level == '0) begin
              dir   <= DIR_UP;
              level <= LEVEL_BITS'(1);
            end else begin
              level <= level - LEVEL_BITS'(1);
            end
          end
        endcase
      end
    end
  end

  // Flash countdown; a request reloads even mid-flash and wins over a tick.
  always_comb begin
    flash_cnt_d_c = flash_cnt;
    if (flash_req) begin
      flash_cnt_d_c = FLASH_LOAD;
    end else if (tick_c && (flash_cnt != '0)) begin
      flash_cnt_d_c = flash_cnt - FL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt <= '0;
    end else begin
      flash_cnt <= flash_cnt_d_c;
    end
  end

  // Per-pixel colour transform selected by the live mode input.
  logic [4:0]      r_c, b_c;
  logic [5:0]      g_c;
  logic [K_W-1:0]  k_c;
  logic [PR_W-1:0] r_prod_c, b_prod_c;
  logic [PG_W-1:0] g_prod_c;

  always_comb begin
    r_c      = bg_colour[15:11];
    g_c      = bg_colour[10:5];
    b_c      = bg_colour[4:0];
    k_c      = K_W'(MAX_LEVEL - level) + K_W'(1);
    r_prod_c = PR_W'(r_c) * PR_W'(k_c);
    g_prod_c = PG_W'(g_c) * PG_W'(k_c);
    b_prod_c = PR_W'(b_c) * PR_W'(k_c);
    colour_c = bg_colour;
    case (mode)
      2'd1: colour_c = {5'(r_prod_c >> LEVEL_BITS),
                        6'(g_prod_c >> LEVEL_BITS),
                        5'(b_prod_c >> LEVEL_BITS)};
      2'd2: begin
        case (phase)
          2'd1:    colour_c = {b_c, r_c, r_c[4], g_c[5:1]};
          2'd2:    colour_c = {g_c[5:1], b_c, b_c[4], r_c};
          default: colour_c = bg_colour;
        endcase
      end
      2'd3:    colour_c = ~bg_colour;
      default: colour_c = bg_colour;
    endcase
  end

  // Output stage runs every cycle, independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_index_q <= '0;
      oled_colour   <= 16'h0000;
      flash_active  <= 1'b0;
    end else begin
      pixel_index_q <= pixel_index;
      flash_active  <= (flash_cnt_d_c != '0);
      oled_colour   <= (flash_cnt_d_c != '0) ? 16'hFFFF : colour_c;
    end
  end

endmodule

// File: tb/tb_background_animator.sv
// Randomised and directed checks of background_animator against a tick/position reference model.
module tb_background_animator;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned PIX_W       = 13;
  localparam int unsigned LEVEL_BITS  = 4;
  localparam int unsigned FLASH_TICKS = 3;
  localparam int          MAX_LVL     = (1 << LEVEL_BITS) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  enable = 1'b1;
  logic [1:0]            mode = 2'd0;
  logic                  flash_req = 1'b0;
  logic [PIX_W-1:0]      pixel_index = '0;
  logic [15:0]           bg_colour = 16'h0000;
  logic [PIX_W-1:0]      pixel_index_q;
  logic [15:0]           oled_colour;
  logic [LEVEL_BITS-1:0] level;
  logic                  flash_active;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: cycle phase within a tick, ticks since last mode change, flash steps left.
  int         m_cnt = 0;
  int         m_pos = 0;
  int         m_flash = 0;
  logic [1:0] m_mode_q = 2'd0;

  background_animator #(
    .TICK_DIV(TICK_DIV), .PIX_W(PIX_W), .LEVEL_BITS(LEVEL_BITS), .FLASH_TICKS(FLASH_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .flash_req(flash_req),
    .pixel_index(pixel_index), .bg_colour(bg_colour), .pixel_index_q(pixel_index_q),
    .oled_colour(oled_colour), .level(level), .flash_active(flash_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tri_level(input int pos);
    int p;
    p = pos % (2 * MAX_LVL);
    return (p <= MAX_LVL) ? p : 2 * MAX_LVL - p;
  endfunction

  function automatic logic [15:0] ref_colour(input logic [1:0] md, input logic [15:0] c,
                                             input int lvl, input int ph);
    int r, g, b, k;
    r = int'(c[15:11]);
    g = int'(c[10:5]);
    b = int'(c[4:0]);
    k = (MAX_LVL + 1) - lvl;
    case (md)
      2'd1: return {5'((r * k) / (MAX_LVL + 1)), 6'((g * k) / (MAX_LVL + 1)),
                    5'((b * k) / (MAX_LVL + 1))};
      2'd2: begin
        if (ph == 1) return {5'(b), 6'(r * 2 + r / 16), 5'(g / 2)};
        if (ph == 2) return {5'(g / 2), 6'(b * 2 + b / 16), 5'(r)};
        return c;
      end
      2'd3: return ~c;
      default: return c;
    endcase
  endfunction

  function automatic bit tick_now();
    return enable && (m_cnt == TICK_DIV - 1);
  endfunction

  // One clock: predict from pre-edge state and inputs, advance the model, compare outputs.
  task automatic step();
    logic [15:0]      e_col;
    logic [PIX_W-1:0] e_pix;
    int               f_next;
    bit               tk;
    tk     = tick_now();
    e_pix  = pixel_index;
    f_next = flash_req ? FLASH_TICKS : ((tk && m_flash > 0) ? m_flash - 1 : m_flash);
    e_col  = (f_next != 0) ? 16'hFFFF
                           : ref_colour(mode, bg_colour, tri_level(m_pos), m_pos % 3);
    @(posedge clk);
    #1;
    m_flash = f_next;
    if (enable) m_cnt = tk ? 0 : m_cnt + 1;
    if (mode != m_mode_q) m_pos = 0;
    else if (tk) m_pos++;
    m_mode_q = mode;
    check("oled_colour", 32'(oled_colour), 32'(e_col));
    check("pixel_index_q", 32'(pixel_index_q), 32'(e_pix));
    check("level", 32'(level), 32'(tri_level(m_pos)));
    check("flash_active", 32'(flash_active), 32'(f_next != 0));
  endtask

  task automatic rand_pixel();
    pixel_index = PIX_W'($urandom_range(0, 6143));
    bg_colour   = 16'($urandom);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pos = 0; m_flash = 0; m_mode_q = 2'd0;
  endtask

  int guard;

  initial begin
    // Reset state
    #2;
    check("rst_oled", 32'(oled_colour), 32'h0);
    check("rst_pix", 32'(pixel_index_q), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_flash", 32'(flash_active), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Passthrough with red and a moving index
    bg_colour = 16'hF800;
    for (int i = 0; i < 8; i++) begin
      pixel_index = PIX_W'(i * 97 + 5);
      step();
    end
    check("pass_red", 32'(oled_colour), 32'hF800);

    // Full fade triangle on white
    mode = 2'd1; bg_colour = 16'hFFFF;
    for (int i = 0; i < 4 * 2 * MAX_LVL + 12; i++) step();

    // Rotation of pure red through all phases
    mode = 2'd2; bg_colour = 16'hF800;
    for (int i = 0; i < 16; i++) step();

    // Mode switch coincident with a tick at level 7
    mode = 2'd1; bg_colour = 16'hFFFF;
    guard = 0;
    do begin step(); guard++; end
    while (!(m_pos == 7 && m_cnt == TICK_DIV - 1) && guard < 200);
    check("mode_sw_reach", 32'(guard < 200), 32'h1);
    mode = 2'd2;
    step();
    check("mode_sw_level", 32'(level), 32'h0);
    for (int i = 0; i < 10; i++) step();

    // Flash over invert, then retrigger after two ticks
    mode = 2'd3; bg_colour = 16'h1234;
    step();
    flash_req = 1'b1; step(); flash_req = 1'b0;
    for (int i = 0; i < 4 * TICK_DIV + 2; i++) step();
    check("flash_end", 32'(oled_colour), 32'hEDCB);
    flash_req = 1'b1; step(); flash_req = 1'b0;
    for (int i = 0; i < 2 * TICK_DIV; i++) step();
    flash_req = 1'b1; step(); flash_req = 1'b0;
    for (int i = 0; i < 4 * TICK_DIV; i++) step();

    // Flash request landing on a tick
    guard = 0;
    while (m_cnt != TICK_DIV - 1 && guard < 10) begin step(); guard++; end
    flash_req = 1'b1; step(); flash_req = 1'b0;
    for (int i = 0; i < 4 * TICK_DIV; i++) step();

    // Freeze mid-fade; outputs keep tracking, flash loads but does not expire
    mode = 2'd1; bg_colour = 16'hFFFF;
    for (int i = 0; i < 23; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_pixel();
      flash_req = (i == 5);
      step();
    end
    flash_req = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) step();

    // Random soak
    for (int i = 0; i < 2000; i++) begin
      rand_pixel();
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      enable    = ($urandom_range(0, 9) != 0);
      flash_req = ($urandom_range(0, 59) == 0);
      step();
    end
    flash_req = 1'b0; enable = 1'b1;

    // Asynchronous reset in mid-cycle
    mode = 2'd3; bg_colour = 16'h00F0; pixel_index = PIX_W'(321);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_oled", 32'(oled_colour), 32'h0);
    check("arst_pix", 32'(pixel_index_q), 32'h0);
    check("arst_level", 32'(level), 32'h0);
    check("arst_flash", 32'(flash_active), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    mode = 2'd0;
    for (int i = 0; i < 12; i++) begin rand_pixel(); step(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
